// File: rtl/piano_pkg.sv
// Shared definitions for the piano tone generator: note table, divisor helper, FSM states.
package piano_pkg;

  localparam int unsigned NOTE_COUNT = 16;

  // Note frequencies in centihertz, C4 upward (entries 8..15 continue the C major scale).
  localparam int unsigned NOTE_CHZ [NOTE_COUNT] = '{
    26160, 29370, 32960, 34920, 39200, 44000, 49390, 52330,
    58730, 65930, 69850, 78400, 88000, 98780, 104650, 117470
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_RELEASE
  } tone_state_e;

  // Full-period divisor in clock cycles, integer-truncated.
  function automatic longint unsigned piano_div(longint unsigned clk_hz, logic [3:0] idx);
    longint unsigned f;
    f = longint'(NOTE_CHZ[idx]);
    return (clk_hz * 64'd100) / f;
  endfunction

endpackage

// File: rtl/piano_tone_gen_key_prio_enc.sv
// Combinational lowest-index priority encoder for the key inputs.
module key_prio_enc #(
  parameter int unsigned NUM_KEYS = 8,
  parameter int unsigned IDX_W    = 3
) (
  input  logic [NUM_KEYS-1:0] keys,
  output logic                valid,
  output logic [IDX_W-1:0]    idx
);

  // Scan from the top down so the lowest asserted bit is written last and wins.
  always_comb begin
    valid = |keys;
    idx   = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/piano_tone_gen.sv
// Square-wave piano tone generator: lowest pressed key selects the note, octave
// shifts it up, note/octave changes are applied only at period boundaries.
module piano_tone_gen
  import piano_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 25000000,
  parameter int unsigned NUM_KEYS = 8,
  parameter int unsigned CNT_W    = 17,
  parameter int unsigned OCT_W    = 2,
  localparam int unsigned IDX_W   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic [OCT_W-1:0]    octave,
  output logic                speaker,
  output logic                active,
  output logic [IDX_W-1:0]    cur_note,
  output logic                period_tick
);

  localparam int unsigned TBL_N = 1 << IDX_W;

  tone_state_e state, state_nxt;

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] note_q, note_nxt;
  logic [OCT_W-1:0] oct_q, oct_nxt;
  logic             spk_nxt, tick_nxt;

  logic             req_valid;
  logic [IDX_W-1:0] req_idx;

  logic [CNT_W-1:0] div_tbl [TBL_N];
  logic [CNT_W-1:0] full_p, half_p;
  logic             last_cnt;

  key_prio_enc #(
    .NUM_KEYS (NUM_KEYS),
    .IDX_W    (IDX_W)
  ) u_enc (
    .keys  (keys),
    .valid (req_valid),
    .idx   (req_idx)
  );

  // Constant per-note divisors; folded at elaboration, no runtime divider.
  for (genvar g = 0; g < TBL_N; g++) begin : g_div
    assign div_tbl[g] = CNT_W'(piano_div(64'(CLK_HZ), 4'(g)));
  end

  // Half period of the latched note/octave, clamped to at least one cycle.
  always_comb begin
    full_p = div_tbl[note_q] >> oct_q;
    half_p = full_p >> 1;
    if (half_p == '0) half_p = CNT_W'(1);
    last_cnt = (cnt == half_p - CNT_W'(1));
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    spk_nxt   = speaker;
    tick_nxt  = 1'b0;
    note_nxt  = note_q;
    oct_nxt   = oct_q;
    unique case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        spk_nxt = 1'b0;
        if (req_valid) begin
          state_nxt = ST_PLAY;
          spk_nxt   = 1'b1;
          note_nxt  = req_idx;
          oct_nxt   = octave;
        end
      end
      ST_PLAY, ST_RELEASE: begin
        state_nxt = req_valid ? ST_PLAY : ST_RELEASE;
        if (!last_cnt) begin
          cnt_nxt = cnt + CNT_W'(1);
        end else begin
          cnt_nxt = '0;
          spk_nxt = ~speaker;
          // The falling edge closes a period: the only point where the note may change
          // or the tone may stop, using the keys sampled on this very cycle.
          if (speaker) begin
            tick_nxt = 1'b1;
            if (req_valid) begin
              note_nxt = req_idx;
              oct_nxt  = octave;
            end else begin
              state_nxt = ST_IDLE;
            end
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      speaker     <= 1'b0;
      period_tick <= 1'b0;
      note_q      <= '0;
      oct_q       <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      speaker     <= spk_nxt;
      period_tick <= tick_nxt;
      note_q      <= note_nxt;
      oct_q       <= oct_nxt;
    end
  end

  assign active   = (state != ST_IDLE);
  assign cur_note = note_q;

endmodule

// File: tb/tb_piano_tone_gen.sv
// Self-checking bench for piano_tone_gen: vector table, corner-case sequences,
// and randomized key/octave activity against a half-period countdown model.
module tb_piano_tone_gen;

  localparam int unsigned CLK_A = 200000;
  localparam int unsigned CLK_C = 1000;
  localparam int LIM = 2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0]  keys8 = '0;
  logic [7:0]  keysc = '0;
  logic [15:0] keys16 = '0;
  logic [1:0]  octave = '0;

  logic spk8, act8, tick8;    logic [2:0] note8;
  logic spk16, act16, tick16; logic [3:0] note16;
  logic spkc, actc, tickc;    logic [2:0] notec;

  always #5 clk = ~clk;

  piano_tone_gen #(.CLK_HZ(CLK_A), .NUM_KEYS(8), .CNT_W(17), .OCT_W(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .keys(keys8), .octave(octave),
    .speaker(spk8), .active(act8), .cur_note(note8), .period_tick(tick8));

  piano_tone_gen #(.CLK_HZ(CLK_A), .NUM_KEYS(16), .CNT_W(17), .OCT_W(2)) dut16 (
    .clk(clk), .rst_n(rst_n), .keys(keys16), .octave(octave),
    .speaker(spk16), .active(act16), .cur_note(note16), .period_tick(tick16));

  piano_tone_gen #(.CLK_HZ(CLK_C), .NUM_KEYS(8), .CNT_W(17), .OCT_W(2)) dutc (
    .clk(clk), .rst_n(rst_n), .keys(keysc), .octave(octave),
    .speaker(spkc), .active(actc), .cur_note(notec), .period_tick(tickc));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference note table (centihertz) and tone rules.
  int unsigned REF_CHZ [16] = '{26160, 29370, 32960, 34920, 39200, 44000, 49390, 52330,
                                58730, 65930, 69850, 78400, 88000, 98780, 104650, 117470};

  function automatic int unsigned half_len(int unsigned note, int unsigned oct);
    longint unsigned p;
    p = (longint'(CLK_A) * 100) / longint'(REF_CHZ[note]);
    p = p >> oct;
    p = p / 2;
    if (p == 0) p = 1;
    return int'(p);
  endfunction

  function automatic logic [2:0] lowest(logic [7:0] k);
    for (int i = 0; i < 8; i++) if (k[i]) return 3'(i);
    return 3'd0;
  endfunction

  // Model: a tone is a chain of half periods; m_left counts cycles left in the current one.
  logic        m_on, m_spk, m_tick;
  logic [2:0]  m_note;
  logic [1:0]  m_oct;
  int unsigned m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_on <= 1'b0; m_spk <= 1'b0; m_tick <= 1'b0;
      m_note <= '0; m_oct <= '0; m_left <= 0;
    end else begin
      m_tick <= 1'b0;
      if (!m_on) begin
        if (keys8 != 0) begin
          m_on <= 1'b1; m_spk <= 1'b1;
          m_note <= lowest(keys8); m_oct <= octave;
          m_left <= half_len(lowest(keys8), octave);
        end
      end else if (m_left > 1) begin
        m_left <= m_left - 1;
      end else if (!m_spk) begin
        m_spk <= 1'b1;
        m_left <= half_len(m_note, m_oct);
      end else begin
        m_spk <= 1'b0; m_tick <= 1'b1;
        if (keys8 == 0) m_on <= 1'b0;
        else begin
          m_note <= lowest(keys8); m_oct <= octave;
          m_left <= half_len(lowest(keys8), octave);
        end
      end
    end
  end

  int sel = 0;
  logic spk_s, tick_s;
  always_comb begin
    case (sel)
      1:       begin spk_s = spk16; tick_s = tick16; end
      2:       begin spk_s = spkc;  tick_s = tickc;  end
      default: begin spk_s = spk8;  tick_s = tick8;  end
    endcase
  end

  task automatic do_reset();
    rst_n = 1'b0; keys8 = '0; keys16 = '0; keysc = '0; octave = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_rise();
    int g;
    g = 0;
    @(negedge clk);
    while (!spk_s && g < 20) begin @(negedge clk); g++; end
  endtask

  task automatic count_lo(output int lo);
    lo = 0;
    while (!spk_s && lo < LIM) begin lo++; @(negedge clk); end
  endtask

  // Waits for the tone to start, then measures one high half, the tick, and one low half.
  task automatic measure(output int hi, output int lo, output logic tk);
    wait_rise();
    hi = 0;
    while (spk_s && hi < LIM) begin hi++; @(negedge clk); end
    tk = tick_s;
    count_lo(lo);
  endtask

  typedef struct {
    logic [7:0]  keys;
    logic [1:0]  oct;
    int unsigned note;
    int unsigned h;
  } vec_t;

  vec_t vecs [8];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

  initial begin : main
    int hi, lo;
    logic tk;

    vecs[0] = '{8'h01, 2'd0, 0, 382};
    vecs[1] = '{8'h21, 2'd0, 0, 382};
    vecs[2] = '{8'h20, 2'd0, 5, 227};
    vecs[3] = '{8'h01, 2'd1, 0, 191};
    vecs[4] = '{8'h80, 2'd1, 7, 95};
    vecs[5] = '{8'hF0, 2'd2, 4, 63};
    vecs[6] = '{8'h60, 2'd2, 5, 56};
    vecs[7] = '{8'h01, 2'd3, 0, 47};

    // Reset state
    #12;
    check("rst_speaker", spk8, 0);
    check("rst_active", act8, 0);
    check("rst_note", note8, 0);
    check("rst_tick", tick8, 0);

    // Table-driven tones
    sel = 0;
    for (int i = 0; i < 8; i++) begin
      do_reset();
      octave = vecs[i].oct;
      keys8 = vecs[i].keys;
      measure(hi, lo, tk);
      check($sformatf("vec%0d_high", i), hi, vecs[i].h);
      check($sformatf("vec%0d_tick", i), tk, 1);
      check($sformatf("vec%0d_note", i), note8, vecs[i].note);
      check($sformatf("vec%0d_low", i), lo, vecs[i].h);
    end

    // Note change mid-period applies only at the next tick
    do_reset(); keys8 = 8'h21; wait_rise(); hi = 0;
    while (spk8 && hi < LIM) begin
      hi++;
      if (hi == 100) keys8 = 8'h20;
      if (hi == 200) check("chg_hold_note", note8, 0);
      @(negedge clk);
    end
    check("chg_high", hi, 382);
    check("chg_tick", tick8, 1);
    check("chg_note", note8, 5);
    count_lo(lo);
    check("chg_low", lo, 227);

    // Release at counter 100, then re-press while idle
    do_reset(); keys8 = 8'h01; wait_rise(); hi = 0;
    while (spk8 && hi < LIM) begin
      hi++;
      if (hi == 101) keys8 = 8'h00;
      if (hi == 200) check("rel_active_hold", act8, 1);
      @(negedge clk);
    end
    check("rel_high", hi, 382);
    check("rel_tick", tick8, 1);
    check("rel_idle_active", act8, 0);
    repeat (50) @(negedge clk);
    check("rel_idle_speaker", spk8, 0);
    keys8 = 8'h01;
    @(negedge clk);
    check("repress_speaker", spk8, 1);
    check("repress_active", act8, 1);

    // Press during RELEASE keeps sounding, new note at tick
    do_reset(); keys8 = 8'h01; wait_rise(); hi = 0;
    while (spk8 && hi < LIM) begin
      hi++;
      if (hi == 101) keys8 = 8'h00;
      if (hi == 200) keys8 = 8'h20;
      @(negedge clk);
    end
    check("relpress_high", hi, 382);
    check("relpress_active", act8, 1);
    check("relpress_note", note8, 5);
    count_lo(lo);
    check("relpress_low", lo, 227);

    // Release sampled on the tick cycle goes straight to idle
    do_reset(); keys8 = 8'h01; wait_rise(); hi = 0;
    while (spk8 && hi < LIM) begin
      hi++;
      if (hi == 382) keys8 = 8'h00;
      @(negedge clk);
    end
    check("simrel_tick", tick8, 1);
    check("simrel_active", act8, 0);

    // Keys changed on the tick cycle: that sample is used
    do_reset(); keys8 = 8'h01; wait_rise(); hi = 0;
    while (spk8 && hi < LIM) begin
      hi++;
      if (hi == 382) keys8 = 8'h20;
      @(negedge clk);
    end
    check("tickchg_note", note8, 5);
    count_lo(lo);
    check("tickchg_low", lo, 227);

    // Asynchronous reset mid-tone, then restart
    do_reset(); keys8 = 8'h20; wait_rise();
    repeat (10) @(negedge clk);
    check("arst_pre_speaker", spk8, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_speaker", spk8, 0);
    check("arst_active", act8, 0);
    check("arst_note", note8, 0);
    check("arst_tick", tick8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    measure(hi, lo, tk);
    check("arst_restart_high", hi, 227);
    check("arst_restart_note", note8, 5);

    // 16-key build
    do_reset(); sel = 1; keys16 = 16'h8000;
    measure(hi, lo, tk);
    check("k16_high", hi, 85);
    check("k16_low", lo, 85);
    check("k16_tick", tk, 1);
    check("k16_note", note16, 15);
    do_reset(); keys16 = 16'h0300;
    measure(hi, lo, tk);
    check("k16b_high", hi, 170);
    check("k16b_note", note16, 8);

    // Half-period clamp at a tiny clock rate
    do_reset(); sel = 2; keysc = 8'h01;
    measure(hi, lo, tk);
    check("clamp_oct0_high", hi, 1);
    check("clamp_oct0_low", lo, 1);
    check("clamp_oct0_tick", tk, 1);
    do_reset(); octave = 2'd1; keysc = 8'h01;
    measure(hi, lo, tk);
    check("clamp_oct1_high", hi, 1);
    check("clamp_oct1_low", lo, 1);
    do_reset(); octave = 2'd3; keysc = 8'h80;
    measure(hi, lo, tk);
    check("clamp_oct3_high", hi, 1);
    check("clamp_oct3_note", notec, 7);

    // Randomized activity against the model
    do_reset(); sel = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      check("rand_outputs", {spk8, act8, tick8, note8}, {m_spk, m_on, m_tick, m_note});
      if ($urandom_range(0, 99) < 3) begin
        case ($urandom_range(0, 2))
          0:       keys8 = 8'h00;
          1:       keys8 = 8'h01 << $urandom_range(0, 7);
          default: keys8 = 8'($urandom_range(0, 255));
        endcase
      end
      if ($urandom_range(0, 99) < 2) octave = 2'($urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
